// File: rtl/s_axi_burst_regfile_if.sv
// s_axi_burst_regfile_if: AXI3 slave bus bundle (AW/W/B/AR/R) for s_axi_burst_regfile
interface s_axi_burst_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] awid_i, bid_o, arid_i, rid_o;
  logic [ADDR_WIDTH-1:0] awaddr_i, araddr_i;
  logic [3:0] awlen_i, arlen_i;
  logic [2:0] awsize_i, arsize_i;
  logic [1:0] awburst_i, arburst_i, bresp_o, rresp_o;
  logic awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
  logic arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
  logic [DATA_WIDTH-1:0] wdata_i, rdata_o;
  logic [DATA_WIDTH/8-1:0] wstrb_i;
  modport slave (
    input awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
    input wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
    input arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
    output awready_o, wready_o, bid_o, bresp_o, bvalid_o,
    output arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
  modport master (
    output awid_i, awaddr_i, awlen_i, awsize_i, awburst_i, awvalid_i,
    output wdata_i, wstrb_i, wlast_i, wvalid_i, bready_i,
    output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
    input awready_o, wready_o, bid_o, bresp_o, bvalid_o,
    input arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/s_axi_burst_regfile.sv
// s_axi_burst_regfile: AXI3 burst register file; S_AXI_BURST_REGFILE_CHECKSUM_EN adds a read-only XOR register at index REG_COUNT
module s_axi_burst_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int ID_WIDTH = 4
) (
  input logic clk,
  input logic areset,
  s_axi_burst_regfile_if.slave bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB = $clog2(BYTES);
  localparam int XW = ADDR_WIDTH - LB;
  localparam int IW = $clog2(REG_COUNT);
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  w_state_t w_st;
  r_state_t r_st;
  addr_t aw_addr, ar_addr;
  logic [3:0] aw_len, ar_len, w_cnt, r_cnt;
  logic [1:0] aw_burst, ar_burst;
  logic [ID_WIDTH-1:0] aw_id;
  logic w_ill, w_err, ar_ill;
  logic [XW-1:0] wi;
  logic w_ok, w_last_pos, w_err_n, aw_ill_n, ar_ill_n;
  function automatic addr_t wmask(input logic [3:0] len);
    return addr_t'({len, {LB{1'b1}}});
  endfunction
  // WRAP keeps the bits above the (len+1)*BYTES window and wraps the rest
  function automatic addr_t next_addr(input addr_t a, input logic [3:0] len, input logic [1:0] bt);
    return bt == 2'b00 ? a : bt == 2'b10 ? (a & ~wmask(len)) | ((a + addr_t'(BYTES)) & wmask(len)) : a + addr_t'(BYTES);
  endfunction
  function automatic logic illegal(input logic [2:0] sz, input logic [1:0] bt, input logic [3:0] len, input logic [LB-1:0] lo);
    return sz != 3'(LB) || bt == 2'b11 || (bt == 2'b10 && (len == 4'd0 || (len & (len + 4'd1)) != 4'd0 || lo != '0));
  endfunction
`ifdef S_AXI_BURST_REGFILE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum;
  always_comb begin
    csum = '0;
    for (int k = 0; k < REG_COUNT; k++) csum = csum ^ regs[k];
  end
`endif
  function automatic logic [DATA_WIDTH+1:0] rd_beat(input logic [XW-1:0] i, input logic ill);
    if (!ill && i < XW'(REG_COUNT)) return {2'b00, regs[i[IW-1:0]]};
`ifdef S_AXI_BURST_REGFILE_CHECKSUM_EN
    if (!ill && i == XW'(REG_COUNT)) return {2'b00, csum};
`endif
    return {2'b10, {DATA_WIDTH{1'b0}}};
  endfunction
  // the checksum index is outside the writable range, so it falls into the SLVERR path
  always_comb begin
    wi = aw_addr[ADDR_WIDTH-1:LB];
    w_ok = !w_ill && wi < XW'(REG_COUNT);
    w_last_pos = w_cnt == aw_len;
    w_err_n = w_err || !w_ok || (bus.wlast_i != w_last_pos);
    aw_ill_n = illegal(bus.awsize_i, bus.awburst_i, bus.awlen_i, bus.awaddr_i[LB-1:0]);
    ar_ill_n = illegal(bus.arsize_i, bus.arburst_i, bus.arlen_i, bus.araddr_i[LB-1:0]);
  end
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      w_st <= W_IDLE;
      bus.awready_o <= 1'b1;
      bus.wready_o <= 1'b0;
      bus.bvalid_o <= 1'b0;
      bus.bresp_o <= 2'b00;
      bus.bid_o <= '0;
      aw_id <= '0;
      aw_addr <= '0;
      aw_len <= '0;
      aw_burst <= '0;
      w_ill <= 1'b0;
      w_err <= 1'b0;
      w_cnt <= '0;
      for (int k = 0; k < REG_COUNT; k++) regs[k] <= '0;
    end else case (w_st)
      W_IDLE: if (bus.awvalid_i) begin
        aw_id <= bus.awid_i;
        aw_addr <= bus.awaddr_i;
        aw_len <= bus.awlen_i;
        aw_burst <= bus.awburst_i;
        w_ill <= aw_ill_n;
        w_err <= aw_ill_n;
        w_cnt <= '0;
        bus.awready_o <= 1'b0;
        bus.wready_o <= 1'b1;
        w_st <= W_DATA;
      end
      W_DATA: if (bus.wvalid_i) begin
        if (w_ok)
          for (int b = 0; b < BYTES; b++)
            if (bus.wstrb_i[b]) regs[wi[IW-1:0]][8*b +: 8] <= bus.wdata_i[8*b +: 8];
        aw_addr <= next_addr(aw_addr, aw_len, aw_burst);
        w_cnt <= w_cnt + 4'd1;
        w_err <= w_err_n;
        if (w_last_pos) begin
          bus.wready_o <= 1'b0;
          bus.bvalid_o <= 1'b1;
          bus.bresp_o <= w_err_n ? 2'b10 : 2'b00;
          bus.bid_o <= aw_id;
          w_st <= W_RESP;
        end
      end
      default: if (bus.bready_i) begin
        bus.bvalid_o <= 1'b0;
        bus.awready_o <= 1'b1;
        w_st <= W_IDLE;
      end
    endcase
  // the next beat is fetched on the handshake edge so bursts stream without bubbles
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      r_st <= R_IDLE;
      bus.arready_o <= 1'b1;
      bus.rvalid_o <= 1'b0;
      bus.rdata_o <= '0;
      bus.rresp_o <= 2'b00;
      bus.rlast_o <= 1'b0;
      bus.rid_o <= '0;
      ar_addr <= '0;
      ar_len <= '0;
      ar_burst <= '0;
      ar_ill <= 1'b0;
      r_cnt <= '0;
    end else if (r_st == R_IDLE) begin
      if (bus.arvalid_i) begin
        {bus.rresp_o, bus.rdata_o} <= rd_beat(bus.araddr_i[ADDR_WIDTH-1:LB], ar_ill_n);
        bus.rlast_o <= bus.arlen_i == 4'd0;
        bus.rid_o <= bus.arid_i;
        bus.rvalid_o <= 1'b1;
        bus.arready_o <= 1'b0;
        ar_addr <= next_addr(bus.araddr_i, bus.arlen_i, bus.arburst_i);
        ar_len <= bus.arlen_i;
        ar_burst <= bus.arburst_i;
        ar_ill <= ar_ill_n;
        r_cnt <= '0;
        r_st <= R_DATA;
      end
    end else if (bus.rready_i) begin
      if (bus.rlast_o) begin
        bus.rvalid_o <= 1'b0;
        bus.rlast_o <= 1'b0;
        bus.arready_o <= 1'b1;
        r_st <= R_IDLE;
      end else begin
        {bus.rresp_o, bus.rdata_o} <= rd_beat(ar_addr[ADDR_WIDTH-1:LB], ar_ill);
        bus.rlast_o <= r_cnt + 4'd1 == ar_len;
        ar_addr <= next_addr(ar_addr, ar_len, ar_burst);
        r_cnt <= r_cnt + 4'd1;
      end
    end
endmodule
